// File: rtl/iiitb_pattern_tx.sv
// Pattern transmitter: sends pattern[len-1:0] MSB-first, rpt+1 times,
// with 'gap' idle cycles between frames. All outputs are registered.
// Next-state and next-output values are built combinationally (_s) and
// captured in a single register stage (_r).
module iiitb_pattern_tx #(
  parameter int WIDTH = 16,
  parameter int GAP_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [WIDTH-1:0]       pattern,
  input  logic [$clog2(WIDTH):0] len,
  input  logic [7:0]             rpt,
  input  logic [GAP_W-1:0]       gap,
  output logic                   dout,
  output logic                   valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [7:0]             frame_cnt
);

  localparam int IW = $clog2(WIDTH);
  localparam int LW = IW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state_r,     state_s;
  logic [WIDTH-1:0] pattern_r,   pattern_s;
  logic [IW-1:0]    len_m1_r,    len_m1_s;
  logic [7:0]       rpt_left_r,  rpt_left_s;
  logic [GAP_W-1:0] gap_r,       gap_s;
  logic [IW-1:0]    bit_idx_r,   bit_idx_s;
  logic [GAP_W-1:0] gap_cnt_r,   gap_cnt_s;
  logic             dout_r,      dout_s;
  logic             valid_r,     valid_s;
  logic             busy_r,      busy_s;
  logic             done_r,      done_s;
  logic             err_r,       err_s;
  logic [7:0]       frame_cnt_r, frame_cnt_s;

  logic             len_ok_s;
  logic [IW-1:0]    len_m1_in_s;

  assign len_ok_s    = (len != LW'(0)) && (len <= LW'(WIDTH));
  // Only meaningful when len_ok_s holds, so len-1 always fits in IW bits.
  assign len_m1_in_s = IW'(len - LW'(1));

  // Next-state and next-output computation for the transmitter FSM.
  always_comb begin
    state_s     = state_r;
    pattern_s   = pattern_r;
    len_m1_s    = len_m1_r;
    rpt_left_s  = rpt_left_r;
    gap_s       = gap_r;
    bit_idx_s   = bit_idx_r;
    gap_cnt_s   = gap_cnt_r;
    dout_s      = dout_r;
    valid_s     = valid_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    err_s       = 1'b0;
    frame_cnt_s = frame_cnt_r;

    case (state_r)
      IDLE: begin
        dout_s  = 1'b0;
        valid_s = 1'b0;
        busy_s  = 1'b0;
        if (start && !abort) begin
          if (len_ok_s) begin
            pattern_s   = pattern;
            len_m1_s    = len_m1_in_s;
            rpt_left_s  = rpt;
            gap_s       = gap;
            frame_cnt_s = 8'd0;
            bit_idx_s   = len_m1_in_s;
            dout_s      = pattern[len_m1_in_s];
            valid_s     = 1'b1;
            busy_s      = 1'b1;
            state_s     = SHIFT;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end

      SHIFT: begin
        if (abort) begin
          state_s = IDLE;
          dout_s  = 1'b0;
          valid_s = 1'b0;
          busy_s  = 1'b0;
        end else if (bit_idx_r != IW'(0)) begin
          bit_idx_s = bit_idx_r - IW'(1);
          dout_s    = pattern_r[bit_idx_r - IW'(1)];
        end else begin
          // Last bit of the frame is on the line now.
          frame_cnt_s = (frame_cnt_r != 8'hFF) ? frame_cnt_r + 8'd1 : frame_cnt_r;
          if (rpt_left_r == 8'd0) begin
            state_s = DONE;
            done_s  = 1'b1;
            dout_s  = 1'b0;
            valid_s = 1'b0;
            busy_s  = 1'b0;
          end else begin
            rpt_left_s = rpt_left_r - 8'd1;
            if (gap_r == GAP_W'(0)) begin
              bit_idx_s = len_m1_r;
              dout_s    = pattern_r[len_m1_r];
            end else begin
              state_s   = GAP;
              gap_cnt_s = gap_r;
              dout_s    = 1'b0;
              valid_s   = 1'b0;
            end
          end
        end
      end

      GAP: begin
        if (abort) begin
          state_s = IDLE;
          dout_s  = 1'b0;
          valid_s = 1'b0;
          busy_s  = 1'b0;
        end else if (gap_cnt_r <= GAP_W'(1)) begin
          state_s   = SHIFT;
          bit_idx_s = len_m1_r;
          dout_s    = pattern_r[len_m1_r];
          valid_s   = 1'b1;
        end else begin
          gap_cnt_s = gap_cnt_r - GAP_W'(1);
        end
      end

      DONE: begin
        state_s = IDLE;
        dout_s  = 1'b0;
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end

      default: begin
        state_s = IDLE;
        dout_s  = 1'b0;
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      pattern_r   <= '0;
      len_m1_r    <= '0;
      rpt_left_r  <= 8'd0;
      gap_r       <= '0;
      bit_idx_r   <= '0;
      gap_cnt_r   <= '0;
      dout_r      <= 1'b0;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      frame_cnt_r <= 8'd0;
    end else begin
      state_r     <= state_s;
      pattern_r   <= pattern_s;
      len_m1_r    <= len_m1_s;
      rpt_left_r  <= rpt_left_s;
      gap_r       <= gap_s;
      bit_idx_r   <= bit_idx_s;
      gap_cnt_r   <= gap_cnt_s;
      dout_r      <= dout_s;
      valid_r     <= valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      err_r       <= err_s;
      frame_cnt_r <= frame_cnt_s;
    end
  end

  assign dout      = dout_r;
  assign valid     = valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign frame_cnt = frame_cnt_r;

endmodule
